psum_bank_buf: RTL and testbench
================================

# psum_bank_buf

Parametrised multi-bank partial-sum buffer that sits between the corelet's SFP output and the core's result port. It replaces fixed two-SRAM chip-select ping-pong with internal fill/drain sequencing. One bank fills, overwriting or accumulating, while previously committed banks drain over a valid/ready stream. Banks rotate round-robin, and address generation is owned by the block instead of instruction fields.

## Interface
- BANKS, 2: number of psum banks (2..8)
- COL, 8: psum lanes per row
- PSUM_BW, 16: bits per lane, signed two's complement
- DEPTH, 64: rows per bank; AW = $clog2(DEPTH)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  pass request; accepted when start && start_ready
- start_ready  out  1  fill FSM in F_IDLE and fill bank not full
- len  in  AW+1  rows in the pass; sampled at start; 0 ignored; >DEPTH clamped to DEPTH
- acc  in  1  sampled at start; 0 = overwrite rows, 1 = add to stored rows
- last  in  1  sampled at start; commit the bank to drain side when the pass ends
- in_valid / in_ready  in / out  1  fill beat handshake
- in_data  in  COL*PSUM_BW  one psum row; lane i = bits [i*PSUM_BW +: PSUM_BW]
- out_valid / out_ready  out / in  1  drain beat handshake
- out_data  out  COL*PSUM_BW  drained row, registered
- out_last  out  1  high with the final row of a drained bank
- fill_bank, drain_bank  out  $clog2(BANKS)  current bank pointers
- full_cnt  out  $clog2(BANKS+1)  committed, not yet fully drained banks

## Operation
- Storage: BANKS x DEPTH x (COL*PSUM_BW) register array, plus a per-bank stored length. Storage is not cleared by reset.
- Fill FSM:
  - F_IDLE: on accepted start with len≠0, latch len/acc/last, set wr_addr=0, go to F_RUN. start with len=0 causes no state change.
  - F_RUN: in_ready=1. Each in fire writes row wr_addr of fill_bank:
    - acc=0: in_data.
    - acc=1: lane-wise sum of stored row and in_data (same-cycle read-modify-write).
  - F_RUN advances wr_addr. On the fire where wr_addr==len-1, the pass ends:
    - last=1: store the bank length, full_cnt++, fill_bank = (fill_bank+1) mod BANKS.
    - Always return to F_IDLE.
- start_ready = (state==F_IDLE) && (full_cnt < BANKS).
- Drain FSM:
  - D_IDLE: if full_cnt>0, set rd_addr=0 and go to D_RUN.
  - D_RUN: out_data/out_valid load the next row when !out_valid || out_ready. After the fire of row len_b-1, where len_b is the bank's stored length, full_cnt-- and drain_bank++ mod BANKS. If full_cnt is still >0, go directly to row 0 of the next bank (no bubble); otherwise go to D_IDLE.
- Simultaneous commit and drain completion in one cycle: full_cnt unchanged, both pointers advance.
- Accumulate onto rows never written since power-up: the result is the sum with undefined content. No protection.
- Reset mid-pass or mid-drain: every FSM goes to idle, all pointers and counters go to 0, in-flight data is discarded.

## Timing
- Reset values: start_ready=1, in_ready=0, out_valid=0, out_data=0, out_last=0, fill_bank=0, drain_bank=0, full_cnt=0.
- Fill: in_ready rises the cycle after start is accepted. One row per cycle at full throughput. in_ready falls the cycle after the final fire.
- Commit to first output: a commit on edge T gives full_cnt update at T. The drain FSM enters D_RUN at T+1, and out_valid=1 with row 0 after T+2.
- Drain: one row per cycle while out_ready=1. out_data/out_valid are held stable while out_valid && !out_ready.
- A bank can be refilled the cycle after its final drain fire.

## Configuration
- PSUM_SAT_EN defined: accumulate lanes saturate to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1].
- PSUM_SAT_EN undefined: accumulate lanes wrap modulo 2^PSUM_BW.
- Overwrite mode is unaffected either way.

## Test plan
All scenarios use BANKS=2, COL=8, PSUM_BW=16, DEPTH=64.
- Overwrite then drain:
  - Stimulus: start len=4 acc=0 last=1; rows where lane i of row r = r*8+i; out_ready=1.
  - Response: 4 rows out in order, out_last on row 3, full_cnt 1→0, first out_valid 2 cycles after commit.
- Accumulate:
  - Stimulus: pass len=2 acc=0 last=0, all lanes 100; then pass len=2 acc=1 last=1, all lanes 23.
  - Response: drain gives all lanes 123.
- Saturation:
  - Stimulus: lanes 0x7FF0 then accumulate 0x0020.
  - Response: 0x7FFF with PSUM_SAT_EN; 0x8010 without.
- Back-pressure and ping-pong:
  - Stimulus: commit bank 0 (len=3), hold out_ready=0, commit bank 1 (len=3).
  - Response: start_ready=0 and full_cnt=2. Release out_ready: 6 rows, bank 0 then bank 1, no bubble. start_ready returns the cycle after bank 0's final fire.
- Boundaries:
  - Stimulus: len=0 start; len=100 start; reset asserted mid-drain.
  - Response: len=0 ignored; len=100 clamped to 64 rows; after reset all outputs at reset values and out_valid=0 the next cycle.

Source files
------------

// File: rtl/psum_bank_buf.sv
// psum_bank_buf: multi-bank partial-sum buffer.
// One bank fills (overwrite or accumulate) while committed banks drain
// over a valid/ready stream. Banks rotate round-robin.
// Optional feature macro: PSUM_SAT_EN (saturating accumulate; wraps when undefined).
module psum_bank_buf #(
    parameter int BANKS   = 2,
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int DEPTH   = 64,
    localparam int AW     = $clog2(DEPTH),
    localparam int BW     = $clog2(BANKS),
    localparam int CW     = $clog2(BANKS + 1),
    localparam int ROW_W  = COL * PSUM_BW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             start_ready,
    input  logic [AW:0]      len,
    input  logic             acc,
    input  logic             last,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ROW_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_data,
    output logic             out_last,
    output logic [BW-1:0]    fill_bank,
    output logic [BW-1:0]    drain_bank,
    output logic [CW-1:0]    full_cnt
);

    typedef enum logic {F_IDLE, F_RUN} fill_state_t;
    typedef enum logic {D_IDLE, D_RUN} drain_state_t;

    // Round-robin bank pointer increment.
    function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] b);
        return (b == BW'(BANKS - 1)) ? '0 : b + BW'(1);
    endfunction

    // Lane-wise accumulate: saturating or wrapping depending on build.
    function automatic logic [PSUM_BW-1:0] lane_add(input logic [PSUM_BW-1:0] a,
                                                     input logic [PSUM_BW-1:0] b);
`ifdef PSUM_SAT_EN
        logic [PSUM_BW:0] s;
        s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
        if (s[PSUM_BW] != s[PSUM_BW-1])
            return s[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
        return s[PSUM_BW-1:0];
`else
        return a + b;
`endif
    endfunction

    // Storage
    logic [ROW_W-1:0] mem      [BANKS][DEPTH];
    logic [AW:0]      bank_len [BANKS];

    // Fill side
    fill_state_t   f_state, f_state_nx;
    logic [AW-1:0] wr_addr;
    logic [AW:0]   f_len;
    logic          f_acc, f_last;
    logic          start_go, in_fire, pass_end, commit;
    logic [AW:0]   len_clamped;
    logic [ROW_W-1:0] old_row, wr_row;

    // Drain side
    drain_state_t  d_state, d_state_nx;
    logic [AW-1:0] rd_addr;
    logic          out_fire, ld_en, chain, bank_done, drop_valid, ld_last;
    logic [BW-1:0] ld_bank;
    logic [AW-1:0] ld_addr;
    logic [ROW_W-1:0] ld_data;

    assign len_clamped = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;

    // Fill FSM next-state and handshake outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        f_state_nx  = f_state;
        start_ready = 1'b0;
        in_ready    = 1'b0;
        start_go    = 1'b0;
        in_fire     = 1'b0;
        pass_end    = 1'b0;
        commit      = 1'b0;
        case (f_state)
            F_IDLE: begin
                start_ready = (full_cnt < CW'(BANKS));
                start_go    = start && start_ready && (len != '0);
                if (start_go) f_state_nx = F_RUN;
            end
            F_RUN: begin
                in_ready = 1'b1;
                in_fire  = in_valid;
                pass_end = in_fire && ({1'b0, wr_addr} == f_len - (AW+1)'(1));
                commit   = pass_end && f_last;
                if (pass_end) f_state_nx = F_IDLE;
            end
            default: f_state_nx = F_IDLE;
        endcase
    end

    // Fill FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignment so all registers update from pre-edge values.
        if (reset) f_state <= F_IDLE;
        else       f_state <= f_state_nx;
    end

    // Fill pass parameters, write address and fill bank pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr   <= '0;
            f_len     <= '0;
            f_acc     <= 1'b0;
            f_last    <= 1'b0;
            fill_bank <= '0;
        end else begin
            if (start_go) begin
                wr_addr <= '0;
                f_len   <= len_clamped;
                f_acc   <= acc;
                f_last  <= last;
            end
            if (in_fire) wr_addr <= wr_addr + AW'(1);
            if (commit)  fill_bank <= bank_inc(fill_bank);
        end
    end

    // Row to write: incoming data, or lane-wise sum with the stored row.
    always_comb begin
        old_row = mem[fill_bank][wr_addr];
        wr_row  = in_data;
        if (f_acc) begin
            for (int i = 0; i < COL; i++)
                wr_row[i*PSUM_BW +: PSUM_BW] = lane_add(old_row[i*PSUM_BW +: PSUM_BW],
                                                        in_data[i*PSUM_BW +: PSUM_BW]);
        end
    end

    // Storage write port and per-bank length capture.
    always_ff @(posedge clk) begin
        // NOTE: the row array is deliberately not reset; only control state is, so it maps to plain storage.
        if (!reset && in_fire) mem[fill_bank][wr_addr] <= wr_row;
        if (!reset && commit)  bank_len[fill_bank]     <= f_len;
    end

    // Drain FSM next-state, load select and bank release.
    always_comb begin
        d_state_nx = d_state;
        ld_en      = 1'b0;
        chain      = 1'b0;
        bank_done  = 1'b0;
        drop_valid = 1'b0;
        out_fire   = out_valid && out_ready;
        case (d_state)
            D_IDLE: if (full_cnt != '0) d_state_nx = D_RUN;
            D_RUN: begin
                if (!out_last) begin
                    ld_en = !out_valid || out_ready;
                end else if (out_fire) begin
                    bank_done = 1'b1;
                    // Another bank was already committed: start it without a bubble.
                    if (full_cnt > CW'(1)) begin
                        chain = 1'b1;
                        ld_en = 1'b1;
                    end else begin
                        drop_valid = 1'b1;
                        d_state_nx = D_IDLE;
                    end
                end
            end
            default: d_state_nx = D_IDLE;
        endcase
        ld_bank = chain ? bank_inc(drain_bank) : drain_bank;
        ld_addr = chain ? '0 : rd_addr;
        ld_data = mem[ld_bank][ld_addr];
        ld_last = ({1'b0, ld_addr} == bank_len[ld_bank] - (AW+1)'(1));
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (reset) d_state <= D_IDLE;
        else       d_state <= d_state_nx;
    end

    // Output register, read address and drain bank pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            rd_addr    <= '0;
            drain_bank <= '0;
        end else begin
            if (d_state == D_IDLE) rd_addr <= '0;
            if (ld_en) begin
                out_data  <= ld_data;
                out_valid <= 1'b1;
                out_last  <= ld_last;
                rd_addr   <= ld_addr + AW'(1);
            end else if (drop_valid) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (bank_done) drain_bank <= bank_inc(drain_bank);
        end
    end

    // Committed-bank counter: commit and drain completion cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_cnt <= '0;
        end else begin
            case ({commit, bank_done})
                2'b10:   full_cnt <= full_cnt + CW'(1);
                2'b01:   full_cnt <= full_cnt - CW'(1);
                default: full_cnt <= full_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_bank_buf.sv
// Directed self-checking bench for psum_bank_buf (BANKS=2, COL=8, PSUM_BW=16, DEPTH=64).
module tb_psum_bank_buf;

    localparam int BANKS = 2, COL = 8, PSUM_BW = 16, DEPTH = 64;
    localparam int AW = $clog2(DEPTH);
    localparam int RW = COL * PSUM_BW;

    logic          clk, reset, start, start_ready, acc, last;
    logic [AW:0]   len;
    logic          in_valid, in_ready, out_valid, out_ready, out_last;
    logic [RW-1:0] in_data, out_data;
    logic          fill_bank, drain_bank;
    logic [1:0]    full_cnt;

    int checks = 0;
    int errors = 0;

    psum_bank_buf #(.BANKS(BANKS), .COL(COL), .PSUM_BW(PSUM_BW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .start_ready(start_ready),
        .len(len), .acc(acc), .last(last),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .fill_bank(fill_bank), .drain_bank(drain_bank),
        .full_cnt(full_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lane i of the row = base*8 + i.
    function automatic logic [RW-1:0] row_pat(input int base);
        logic [RW-1:0] r;
        for (int i = 0; i < COL; i++) r[i*PSUM_BW +: PSUM_BW] = 16'(base * COL + i);
        return r;
    endfunction

    function automatic logic [RW-1:0] row_all(input logic [15:0] v);
        return {COL{v}};
    endfunction

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // One fill pass: waits (bounded) for start_ready, then streams n rows back to back.
    task automatic fill(input int l, input bit a, input bit lst, input int n,
                        input bit use_pat, input int base, input logic [15:0] val);
        int w = 0;
        while (!start_ready && w < 50) begin tick(); w++; end
        check("fill_start_ready_wait", start_ready, 1);
        start = 1'b1; len = (AW+1)'(l); acc = a; last = lst;
        tick();
        start = 1'b0;
        for (int r = 0; r < n; r++) begin
            in_valid = 1'b1;
            in_data  = use_pat ? row_pat(base + r) : row_all(val);
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Collect n drained rows with out_ready=1, checking data and out_last.
    task automatic drain_collect(input string tag, input int n, input bit use_pat,
                                 input int base, input logic [15:0] val);
        for (int k = 0; k < n; k++) begin
            int w = 0;
            while (!out_valid && w < 20) begin tick(); w++; end
            check($sformatf("%s_valid%0d", tag, k), out_valid, 1);
            check($sformatf("%s_data%0d", tag, k), out_data,
                  use_pat ? row_pat(base + k) : row_all(val));
            check($sformatf("%s_last%0d", tag, k), out_last, (k == n - 1));
            tick();
        end
    endtask

    initial begin
        int cnt;
        logic [15:0] sat_exp;
        reset = 1'b1; start = 1'b0; len = '0; acc = 1'b0; last = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();

        // Reset values
        check("rst_start_ready", start_ready, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_fill_bank", fill_bank, 0);
        check("rst_drain_bank", drain_bank, 0);
        check("rst_full_cnt", full_cnt, 0);
        reset = 1'b0;
        out_ready = 1'b1;

        // Overwrite then drain, cycle-exact
        start = 1'b1; len = 7'd4; acc = 1'b0; last = 1'b1;
        tick();
        start = 1'b0;
        check("ow_in_ready_rise", in_ready, 1);
        check("ow_start_ready_busy", start_ready, 0);
        for (int r = 0; r < 4; r++) begin
            in_valid = 1'b1; in_data = row_pat(r);
            tick();
        end
        in_valid = 1'b0;
        check("ow_in_ready_fall", in_ready, 0);
        check("ow_full_cnt_commit", full_cnt, 1);
        check("ow_fill_bank_adv", fill_bank, 1);
        check("ow_out_valid_T", out_valid, 0);
        tick();
        check("ow_out_valid_T1", out_valid, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ow_valid%0d", k), out_valid, 1);
            check($sformatf("ow_data%0d", k), out_data, row_pat(k));
            check($sformatf("ow_last%0d", k), out_last, (k == 3));
            tick();
        end
        check("ow_valid_drop", out_valid, 0);
        check("ow_full_cnt_done", full_cnt, 0);
        check("ow_drain_bank_adv", drain_bank, 1);

        // Accumulate 100 + 23
        fill(2, 1'b0, 1'b0, 2, 1'b0, 0, 16'd100);
        check("acc_no_commit_cnt", full_cnt, 0);
        check("acc_no_commit_bank", fill_bank, 1);
        fill(2, 1'b1, 1'b1, 2, 1'b0, 0, 16'd23);
        drain_collect("acc", 2, 1'b0, 0, 16'd123);

        // Saturation / wrap
`ifdef PSUM_SAT_EN
        sat_exp = 16'h7FFF;
`else
        sat_exp = 16'h8010;
`endif
        fill(1, 1'b0, 1'b0, 1, 1'b0, 0, 16'h7FF0);
        fill(1, 1'b1, 1'b1, 1, 1'b0, 0, 16'h0020);
        drain_collect("sat", 1, 1'b0, 0, sat_exp);

        // Back-pressure and ping-pong
        do_reset();
        out_ready = 1'b0;
        fill(3, 1'b0, 1'b1, 3, 1'b1, 10, 16'd0);
        fill(3, 1'b0, 1'b1, 3, 1'b1, 20, 16'd0);
        tick(); tick();
        check("bp_start_ready", start_ready, 0);
        check("bp_full_cnt", full_cnt, 2);
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data", out_data, row_pat(10));
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("pp_valid%0d", k), out_valid, 1);
            check($sformatf("pp_data%0d", k), out_data, (k < 3) ? row_pat(10 + k) : row_pat(17 + k));
            check($sformatf("pp_last%0d", k), out_last, (k == 2 || k == 5));
            check($sformatf("pp_drain_bank%0d", k), drain_bank, (k >= 3));
            if (k == 2) check("pp_start_ready_before", start_ready, 0);
            if (k == 3) begin
                check("pp_start_ready_after", start_ready, 1);
                check("pp_full_cnt_mid", full_cnt, 1);
            end
            tick();
        end
        check("pp_valid_end", out_valid, 0);
        check("pp_full_cnt_end", full_cnt, 0);

        // len=0 ignored
        start = 1'b1; len = '0; acc = 1'b0; last = 1'b1;
        tick();
        start = 1'b0;
        check("len0_in_ready", in_ready, 0);
        check("len0_start_ready", start_ready, 1);
        check("len0_full_cnt", full_cnt, 0);

        // len=100 clamped to 64
        start = 1'b1; len = 7'd100; acc = 1'b0; last = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 120; c++) begin
            if (!in_ready) break;
            in_valid = 1'b1; in_data = row_pat(cnt);
            tick();
            cnt++;
        end
        in_valid = 1'b0;
        check("clamp_rows", cnt, 64);
        check("clamp_full_cnt", full_cnt, 1);
        drain_collect("clamp", 64, 1'b1, 0, 16'd0);

        // Reset mid-drain
        fill(4, 1'b0, 1'b1, 4, 1'b1, 40, 16'd0);
        cnt = 0;
        while (!out_valid && cnt < 20) begin tick(); cnt++; end
        check("mrst_valid_before", out_valid, 1);
        tick();
        reset = 1'b1;
        tick();
        check("mrst_out_valid", out_valid, 0);
        check("mrst_out_data", out_data, 0);
        check("mrst_out_last", out_last, 0);
        check("mrst_full_cnt", full_cnt, 0);
        check("mrst_fill_bank", fill_bank, 0);
        check("mrst_drain_bank", drain_bank, 0);
        check("mrst_start_ready", start_ready, 1);
        check("mrst_in_ready", in_ready, 0);
        reset = 1'b0;
        tick();
        check("mrst_out_valid_next", out_valid, 0);
        check("mrst_full_cnt_next", full_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
